account_ledger_unit: RTL and testbench

- Downstream stage of the payment-processing block. Consumes its per-transaction result: excess flag, short flag and 16-bit adjustment amount.
- Maintains the customer's carry-forward credit and outstanding arrears across billing periods.
- Applies late fees at period close and raises a sticky disconnect request after repeated overdue periods.
- Outputs feed the tariff/billing front end (next bill netting) and the supply-control logic.

---
 rtl/billing_pkg.sv | 38 +++
 rtl/ledger_netting_core.sv | 46 ++++
 rtl/account_ledger_unit.sv | 118 +++++++++++
 tb/tb_account_ledger_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/billing_pkg.sv
// Types and helpers shared by the payment-processing, ledger and tariff blocks.
package billing_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CLOSE = 2'd2
  } ledger_state_t;

  localparam int          BAL_W_DEFAULT    = 20;
  localparam logic [15:0] LATE_FEE_DEFAULT = 16'd50;
  localparam int          SAT_ADD_W        = 32;

  typedef struct packed {
    logic [SAT_ADD_W-1:0] value;
    logic                 sat;
  } sat_sum_t;

  // Unsigned add clamped to 2^width-1; width must be 1..32.
  function automatic sat_sum_t sat_add(input logic [SAT_ADD_W-1:0] a,
                                       input logic [SAT_ADD_W-1:0] b,
                                       input int unsigned          width);
    logic [SAT_ADD_W:0] sum;
    logic [SAT_ADD_W:0] limit;
    sat_sum_t           r;
    sum   = {1'b0, a} + {1'b0, b};
    limit = (33'd1 << width) - 33'd1;
    if (sum > limit) begin
      r.value = limit[SAT_ADD_W-1:0];
      r.sat   = 1'b1;
    end else begin
      r.value = sum[SAT_ADD_W-1:0];
      r.sat   = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/ledger_netting_core.sv
// Combinational netting of one payment result against credit and arrears.
module ledger_netting_core
  import billing_pkg::*;
#(
  parameter int BAL_W = BAL_W_DEFAULT
) (
  input  logic [BAL_W-1:0] credit,
  input  logic [BAL_W-1:0] arrears,
  input  logic [BAL_W-1:0] amount,
  input  logic             excess,
  input  logic             short_pay,
  output logic [BAL_W-1:0] credit_next,
  output logic [BAL_W-1:0] arrears_next,
  output logic             sat
);

  sat_sum_t sum;

  // NOTE: every output gets a default first so no path leaves a latch behind.
  always_comb begin
    credit_next  = credit;
    arrears_next = arrears;
    sat          = 1'b0;
    sum          = '0;
    if (excess && !short_pay) begin
      if (arrears >= amount) begin
        arrears_next = arrears - amount;
      end else begin
        sum          = sat_add(32'(credit), 32'(amount - arrears), BAL_W);
        credit_next  = sum.value[BAL_W-1:0];
        sat          = sum.sat;
        arrears_next = '0;
      end
    end else if (short_pay && !excess) begin
      if (credit >= amount) begin
        credit_next = credit - amount;
      end else begin
        sum          = sat_add(32'(arrears), 32'(amount - credit), BAL_W);
        arrears_next = sum.value[BAL_W-1:0];
        sat          = sum.sat;
        credit_next  = '0;
      end
    end
  end

endmodule

// File: rtl/account_ledger_unit.sv
// Customer ledger: nets payment results, charges late fees at period close,
// and raises a sticky disconnect request after repeated overdue periods.
module account_ledger_unit
  import billing_pkg::*;
#(
  parameter int          BAL_W         = BAL_W_DEFAULT,
  parameter logic [15:0] LATE_FEE      = LATE_FEE_DEFAULT,
  parameter int          GRACE_PERIODS = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             result_valid,
  input  logic             excess_payment,
  input  logic             short_payment,
  input  logic [15:0]      adjustment_amount,
  input  logic             period_tick,
  output logic             ready,
  output logic [BAL_W-1:0] credit_balance,
  output logic [BAL_W-1:0] arrears_balance,
  output logic [3:0]       overdue_count,
  output logic             late_fee_pulse,
  output logic             disconnect_req,
  output logic             sat_flag
);

  localparam logic [3:0] GRACE = 4'(GRACE_PERIODS);

  ledger_state_t    state, state_next;
  logic [15:0]      adj_q;
  logic             excess_q, short_q, tick_pending;
  logic             accept;
  logic [BAL_W-1:0] amount_ext;
  logic [BAL_W-1:0] net_credit, net_arrears;
  logic             net_sat;
  sat_sum_t         fee_sum;
  logic [3:0]       overdue_inc;

  assign ready       = (state == IDLE);
  assign accept      = result_valid && ready;
  assign amount_ext  = BAL_W'(adj_q);
  assign fee_sum     = sat_add(32'(arrears_balance), 32'(LATE_FEE), BAL_W);
  assign overdue_inc = (overdue_count == 4'hF) ? 4'hF : overdue_count + 4'd1;

  ledger_netting_core #(.BAL_W(BAL_W)) u_netting (
    .credit      (credit_balance),
    .arrears     (arrears_balance),
    .amount      (amount_ext),
    .excess      (excess_q),
    .short_pay   (short_q),
    .credit_next (net_credit),
    .arrears_next(net_arrears),
    .sat         (net_sat)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept)                           state_next = APPLY;
        else if (period_tick || tick_pending) state_next = CLOSE;
      end
      APPLY:   state_next = tick_pending ? CLOSE : IDLE;
      CLOSE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      adj_q           <= '0;
      excess_q        <= 1'b0;
      short_q         <= 1'b0;
      tick_pending    <= 1'b0;
      credit_balance  <= '0;
      arrears_balance <= '0;
      overdue_count   <= '0;
      late_fee_pulse  <= 1'b0;
      disconnect_req  <= 1'b0;
      sat_flag        <= 1'b0;
    end else begin
      state          <= state_next;
      late_fee_pulse <= 1'b0;
      // Entering CLOSE consumes every tick seen so far, merging duplicates.
      if (state_next == CLOSE)  tick_pending <= 1'b0;
      else if (period_tick)     tick_pending <= 1'b1;
      if (accept) begin
        adj_q    <= adjustment_amount;
        excess_q <= excess_payment;
        short_q  <= short_payment;
      end
      if (arrears_balance == '0) begin
        overdue_count  <= '0;
        disconnect_req <= 1'b0;
      end
      case (state)
        APPLY: begin
          credit_balance  <= net_credit;
          arrears_balance <= net_arrears;
          sat_flag        <= sat_flag | net_sat;
        end
        CLOSE: begin
          if (arrears_balance != '0) begin
            arrears_balance <= fee_sum.value[BAL_W-1:0];
            sat_flag        <= sat_flag | fee_sum.sat;
            late_fee_pulse  <= 1'b1;
            overdue_count   <= overdue_inc;
            if (overdue_inc >= GRACE) disconnect_req <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_account_ledger_unit.sv
// Directed bench for account_ledger_unit (16-bit balances, grace of 2 periods).
module tb_account_ledger_unit;

  localparam int BW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          result_valid = 1'b0;
  logic          excess_payment = 1'b0;
  logic          short_payment = 1'b0;
  logic [15:0]   adjustment_amount = '0;
  logic          period_tick = 1'b0;
  logic          ready;
  logic [BW-1:0] credit_balance;
  logic [BW-1:0] arrears_balance;
  logic [3:0]    overdue_count;
  logic          late_fee_pulse;
  logic          disconnect_req;
  logic          sat_flag;

  int checks = 0;
  int errors = 0;

  account_ledger_unit #(.BAL_W(BW), .LATE_FEE(16'd50), .GRACE_PERIODS(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .result_valid     (result_valid),
    .excess_payment   (excess_payment),
    .short_payment    (short_payment),
    .adjustment_amount(adjustment_amount),
    .period_tick      (period_tick),
    .ready            (ready),
    .credit_balance   (credit_balance),
    .arrears_balance  (arrears_balance),
    .overdue_count    (overdue_count),
    .late_fee_pulse   (late_fee_pulse),
    .disconnect_req   (disconnect_req),
    .sat_flag         (sat_flag)
  );

  always #5 clk = ~clk;

  // Drives one cycle of inputs; returns at the falling edge after the sampling edge.
  task automatic drive(input logic rv, input logic ex, input logic sh,
                       input logic [15:0] amt, input logic tick);
    @(negedge clk);
    result_valid      = rv;
    excess_payment    = ex;
    short_payment     = sh;
    adjustment_amount = amt;
    period_tick       = tick;
    @(negedge clk);
    result_valid      = 1'b0;
    excess_payment    = 1'b0;
    short_payment     = 1'b0;
    adjustment_amount = '0;
    period_tick       = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0d expected 1", ready); end
    checks++; if (credit_balance !== 16'd0) begin errors++; $display("FAIL reset_credit: got %0d expected 0", credit_balance); end
    checks++; if (arrears_balance !== 16'd0) begin errors++; $display("FAIL reset_arrears: got %0d expected 0", arrears_balance); end
    checks++; if ({overdue_count, late_fee_pulse, disconnect_req, sat_flag} !== 7'd0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000000", {overdue_count, late_fee_pulse, disconnect_req, sat_flag}); end
  endtask

  task automatic test_short_then_excess();
    do_reset();
    drive(1, 0, 1, 16'd300, 0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ste_busy: ready got %0d expected 0", ready); end
    checks++; if (arrears_balance !== 16'd0) begin errors++; $display("FAIL ste_early: arrears got %0d expected 0", arrears_balance); end
    @(negedge clk);
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL ste_ready_back: got %0d expected 1", ready); end
    checks++; if (arrears_balance !== 16'd300 || credit_balance !== 16'd0) begin
      errors++; $display("FAIL ste_short: arrears %0d credit %0d expected 300 0", arrears_balance, credit_balance); end
    drive(1, 1, 0, 16'd500, 0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL ste_busy2: ready got %0d expected 0", ready); end
    @(negedge clk);
    checks++; if (arrears_balance !== 16'd0 || credit_balance !== 16'd200) begin
      errors++; $display("FAIL ste_excess: arrears %0d credit %0d expected 0 200", arrears_balance, credit_balance); end
  endtask

  task automatic test_late_fee();
    do_reset();
    drive(1, 0, 1, 16'd100, 0);
    @(negedge clk);
    drive(0, 0, 0, 16'd0, 1);
    checks++; if (ready !== 1'b0 || late_fee_pulse !== 1'b0) begin
      errors++; $display("FAIL lf_in_close: ready %0d pulse %0d expected 0 0", ready, late_fee_pulse); end
    @(negedge clk);
    checks++; if (arrears_balance !== 16'd150) begin errors++; $display("FAIL lf_fee1: arrears got %0d expected 150", arrears_balance); end
    checks++; if (late_fee_pulse !== 1'b1 || overdue_count !== 4'd1 || disconnect_req !== 1'b0) begin
      errors++; $display("FAIL lf_close1: pulse %0d overdue %0d disc %0d expected 1 1 0", late_fee_pulse, overdue_count, disconnect_req); end
    @(negedge clk);
    checks++; if (late_fee_pulse !== 1'b0) begin errors++; $display("FAIL lf_pulse_width: got %0d expected 0", late_fee_pulse); end
    drive(1, 0, 1, 16'd100, 0);
    @(negedge clk);
    drive(0, 0, 0, 16'd0, 1);
    @(negedge clk);
    checks++; if (arrears_balance !== 16'd300) begin errors++; $display("FAIL lf_fee2: arrears got %0d expected 300", arrears_balance); end
    checks++; if (overdue_count !== 4'd2 || disconnect_req !== 1'b1) begin
      errors++; $display("FAIL lf_disc_set: overdue %0d disc %0d expected 2 1", overdue_count, disconnect_req); end
    drive(1, 1, 0, 16'd300, 0);
    @(negedge clk);
    checks++; if (arrears_balance !== 16'd0 || disconnect_req !== 1'b1 || overdue_count !== 4'd2) begin
      errors++; $display("FAIL lf_paid: arrears %0d disc %0d overdue %0d expected 0 1 2", arrears_balance, disconnect_req, overdue_count); end
    @(negedge clk);
    checks++; if (disconnect_req !== 1'b0 || overdue_count !== 4'd0) begin
      errors++; $display("FAIL lf_disc_clear: disc %0d overdue %0d expected 0 0", disconnect_req, overdue_count); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    drive(1, 0, 1, 16'd80, 0);
    @(negedge clk);
    drive(1, 1, 0, 16'd80, 1);
    @(negedge clk);
    checks++; if (arrears_balance !== 16'd0 || ready !== 1'b0) begin
      errors++; $display("FAIL sim_applied: arrears %0d ready %0d expected 0 0", arrears_balance, ready); end
    @(negedge clk);
    checks++; if (late_fee_pulse !== 1'b0 || arrears_balance !== 16'd0 || overdue_count !== 4'd0 || ready !== 1'b1) begin
      errors++; $display("FAIL sim_close: pulse %0d arrears %0d overdue %0d ready %0d expected 0 0 0 1",
                         late_fee_pulse, arrears_balance, overdue_count, ready); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(negedge clk);
    result_valid = 1'b1; short_payment = 1'b1; adjustment_amount = 16'd100; period_tick = 1'b1;
    @(negedge clk);
    result_valid = 1'b0; short_payment = 1'b0; adjustment_amount = '0;
    @(negedge clk);
    period_tick = 1'b0;
    checks++; if (arrears_balance !== 16'd100 || ready !== 1'b0) begin
      errors++; $display("FAIL b2b_apply: arrears %0d ready %0d expected 100 0", arrears_balance, ready); end
    @(negedge clk);
    checks++; if (arrears_balance !== 16'd150 || late_fee_pulse !== 1'b1 || overdue_count !== 4'd1) begin
      errors++; $display("FAIL b2b_close: arrears %0d pulse %0d overdue %0d expected 150 1 1", arrears_balance, late_fee_pulse, overdue_count); end
    @(negedge clk);
    checks++; if (arrears_balance !== 16'd150 || late_fee_pulse !== 1'b0 || ready !== 1'b1) begin
      errors++; $display("FAIL b2b_merged: arrears %0d pulse %0d ready %0d expected 150 0 1", arrears_balance, late_fee_pulse, ready); end
  endtask

  task automatic test_busy_ignored();
    do_reset();
    @(negedge clk);
    result_valid = 1'b1; short_payment = 1'b1; adjustment_amount = 16'd100;
    @(negedge clk);
    @(negedge clk);
    result_valid = 1'b0; short_payment = 1'b0; adjustment_amount = '0;
    @(negedge clk);
    checks++; if (arrears_balance !== 16'd100) begin errors++; $display("FAIL busy_ignored: arrears got %0d expected 100", arrears_balance); end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 1, 0, 16'd65000, 0);
    @(negedge clk);
    checks++; if (credit_balance !== 16'd65000 || sat_flag !== 1'b0) begin
      errors++; $display("FAIL sat_pre: credit %0d sat %0d expected 65000 0", credit_balance, sat_flag); end
    drive(1, 1, 0, 16'd1000, 0);
    @(negedge clk);
    checks++; if (credit_balance !== 16'd65535 || sat_flag !== 1'b1) begin
      errors++; $display("FAIL sat_hit: credit %0d sat %0d expected 65535 1", credit_balance, sat_flag); end
    drive(1, 0, 1, 16'd10, 0);
    @(negedge clk);
    checks++; if (credit_balance !== 16'd65525 || sat_flag !== 1'b1 || arrears_balance !== 16'd0) begin
      errors++; $display("FAIL sat_sticky: credit %0d sat %0d arrears %0d expected 65525 1 0", credit_balance, sat_flag, arrears_balance); end
  endtask

  task automatic test_reset_in_apply();
    do_reset();
    drive(1, 0, 1, 16'd100, 0);
    @(negedge clk);
    drive(1, 0, 1, 16'd50, 0);
    reset = 1'b1;
    #1;
    checks++; if (ready !== 1'b1 || arrears_balance !== 16'd0 || credit_balance !== 16'd0) begin
      errors++; $display("FAIL rst_apply_now: ready %0d arrears %0d credit %0d expected 1 0 0", ready, arrears_balance, credit_balance); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (arrears_balance !== 16'd0 || ready !== 1'b1) begin
      errors++; $display("FAIL rst_apply_drop: arrears %0d ready %0d expected 0 1", arrears_balance, ready); end
    drive(0, 0, 0, 16'd0, 1);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_tick_close: ready got %0d expected 0", ready); end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || late_fee_pulse !== 1'b0 || overdue_count !== 4'd0) begin
      errors++; $display("FAIL rst_tick_done: ready %0d pulse %0d overdue %0d expected 1 0 0", ready, late_fee_pulse, overdue_count); end
  endtask

  task automatic test_illegal_flags();
    do_reset();
    drive(1, 0, 1, 16'd70, 0);
    @(negedge clk);
    drive(1, 1, 1, 16'd40, 0);
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL both_busy: ready got %0d expected 0", ready); end
    @(negedge clk);
    checks++; if (ready !== 1'b1 || arrears_balance !== 16'd70 || credit_balance !== 16'd0) begin
      errors++; $display("FAIL both_nochange: ready %0d arrears %0d credit %0d expected 1 70 0", ready, arrears_balance, credit_balance); end
    drive(1, 0, 0, 16'd40, 0);
    @(negedge clk);
    checks++; if (arrears_balance !== 16'd70 || credit_balance !== 16'd0) begin
      errors++; $display("FAIL none_nochange: arrears %0d credit %0d expected 70 0", arrears_balance, credit_balance); end
  endtask

  initial begin
    test_reset();
    test_short_then_excess();
    test_late_fee();
    test_simultaneous();
    test_back_to_back();
    test_busy_ignored();
    test_saturation();
    test_reset_in_apply();
    test_illegal_flags();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
